// File: rtl/cond_move_pipe.sv
// Pipelined MIPS conditional-move gate (PASS/MOVZ/MOVN/KILL) with stall, flush and STAGES register stages.
// Optional suppressed-write counter enabled by defining COND_MOVE_STAT_EN.
module cond_move_pipe #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [WIDTH-1:0]  in_cmp,
  input  logic [1:0]        in_mode,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              stall,
  input  logic              flush,
`ifdef COND_MOVE_STAT_EN
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  suppress_cnt,
`endif
  output logic              out_valid,
  output logic              out_cond,
  output logic              out_we,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_MOVZ = 2'b01,
    MODE_MOVN = 2'b10,
    MODE_KILL = 2'b11
  } mode_e;

  typedef struct packed {
    logic              valid;
    logic              cond;
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] addr;
  } stage_t;

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("cond_move_pipe: STAGES must be in 1..4");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("cond_move_pipe: CNT_W must be at least 1");
    end
  endgenerate

  logic   cond;
  stage_t s1_in;
  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];

  always_comb begin
    cond = 1'b0;
    unique case (mode_e'(in_mode))
      MODE_PASS: cond = 1'b1;
      MODE_MOVZ: cond = (in_cmp == '0);
      MODE_MOVN: cond = (in_cmp != '0);
      MODE_KILL: cond = 1'b0;
      default:   cond = 1'b0;
    endcase
  end

  // Gating happens at stage-1 capture; an invalid input becomes an all-zero bubble.
  always_comb begin
    s1_in = '0;
    if (in_valid) begin
      s1_in.valid = 1'b1;
      s1_in.cond  = cond;
      s1_in.data  = cond ? in_data : '0;
      s1_in.addr  = cond ? in_addr : '0;
    end
  end

  always_comb begin
    // NOTE: every stage_d gets a default (hold) before any branch, so no path infers a latch.
    for (int i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_d[i] = '0;
      end
    end else if (!stall) begin
      stage_d[0] = s1_in;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data/addr are reset along with valid/cond so every output reads 0 after reset, not stale data.
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign out_cond  = stage_q[STAGES-1].cond;
  assign out_data  = stage_q[STAGES-1].data;
  assign out_addr  = stage_q[STAGES-1].addr;
  assign out_we    = out_valid & out_cond & (out_addr != '0);

`ifdef COND_MOVE_STAT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             suppress_hit;

  assign suppress_hit = in_valid & ~stall & ~flush & ~cond;

  // Saturating count of valid captures whose write was suppressed; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (suppress_hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign suppress_cnt = cnt_q;
`endif

endmodule
